fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first instruction address after reset.
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port imem_req  out  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_addr  out  32  fetch address, word-aligned.
REQ-006 SHALL have port imem_gnt  in  1  memory accepted request.
REQ-007 SHALL have port imem_rvalid  in  1  imem_rdata valid this cycle.
REQ-008 SHALL have port imem_rdata  in  32  fetched instruction word.
REQ-009 SHALL have port id_valid  out  1  instruction register holds a valid instruction for decode.
REQ-010 SHALL have port id_ready  in  1  decode/execute consumes instruction this cycle.
REQ-011 SHALL have port instr  out  32  held instruction word.
REQ-012 SHALL have ports op  out  7, funct3  out  3, funct7  out  7: instr[6:0], instr[14:12], instr[31:25], feeding control_unit_top.
REQ-013 SHALL have ports pc, pc_plus4  out  32  address of held instruction, and that address + 4.
REQ-014 SHALL have port redirect_en  in  1  taken branch/jump (PCSrc/Jump) for held instruction.
REQ-015 SHALL have port redirect_target  in  32  next-PC when redirect_en.
REQ-016 SHALL have port misalign_err  out  1  one-cycle pulse on misaligned redirect.
REQ-017 SHALL have port instret  out  32  count of consumed instructions.

Function
REQ-018 SHALL implement FSM states S_REQ, S_WAIT, S_VALID.
REQ-019 S_REQ SHALL drive imem_req=1, imem_addr=fetch_pc; on imem_gnt go to S_WAIT, else stay.
REQ-020 S_WAIT SHALL drive imem_req=0; on imem_rvalid capture imem_rdata into instr and fetch_pc into pc, go to S_VALID.
REQ-021 imem_rvalid in the same cycle as imem_gnt SHALL NOT be accepted; data is taken only in S_WAIT.
REQ-022 S_VALID SHALL drive id_valid=1; instr, pc and op/funct fields SHALL remain stable until handshake (id_valid && id_ready).
REQ-023 On handshake fetch_pc SHALL load redirect_target when redirect_en=1, else pc+4, and FSM SHALL go to S_REQ.
REQ-024 redirect_en SHALL be sampled only at handshake; assertion at any other time SHALL be ignored.
REQ-025 redirect_target[1:0]!=0 at handshake SHALL force those bits to 0 in fetch_pc and pulse misalign_err for exactly one cycle.
REQ-026 Minimum fetch-to-consume latency SHALL be 3 cycles (grant in S_REQ, rvalid in next cycle, handshake in following cycle).
REQ-027 pc+4 and instret arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0, instret wraps 32'hFFFF_FFFF to 0.
REQ-028 instret SHALL increment by 1 on every handshake, never otherwise.
REQ-029 id_valid SHALL be 0 in S_REQ and S_WAIT.

Reset
REQ-030 rst=0 SHALL asynchronously force state S_REQ, fetch_pc=RESET_PC, pc=RESET_PC, instr=32'h0000_0013 (NOP), instret=0, misalign_err=0, id_valid=0.
REQ-031 Reset during S_WAIT SHALL discard the outstanding response; a stale imem_rvalid in first post-reset cycle (state S_REQ) SHALL be ignored.
REQ-032 First imem_req SHALL assert in the first clk edge-cycle after rst deasserts, with imem_addr=RESET_PC.

Structure
REQ-033 State encoding, RESET_PC default, NOP constant and instruction field bit positions SHALL live in shared package riscv_pkg.
REQ-034 Next-PC selection (pc+4 / aligned redirect_target) SHALL be one combinational sub-module pc_next; FSM, registers and counter stay in fetch_unit.

Verification
REQ-035 Reset release, imem_gnt=1 always, rvalid one cycle later, id_ready=1 -> addrs 0,4,8 fetched, id_valid every 3rd cycle, instret=3 after three handshakes.
REQ-036 Hold id_ready=0 for 5 cycles in S_VALID with redirect_en pulsing -> instr/pc stable, no imem_req, redirect ignored, instret unchanged.
REQ-037 At handshake of pc=0x10 redirect_en=1, target=0x100 -> next imem_addr=0x100; target=0x102 -> imem_addr=0x100, misalign_err pulses one cycle.
REQ-038 Delay imem_gnt 4 cycles and imem_rvalid 3 cycles -> imem_addr stable through S_REQ, instr captures rdata only on rvalid in S_WAIT.
REQ-039 Assert rst mid-S_WAIT, then rvalid after release -> response dropped, refetch from RESET_PC, instret=0.
REQ-040 pc=0xFFFF_FFFC handshake without redirect -> next imem_addr=0x0; preload instret=0xFFFF_FFFF -> wraps to 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM states, reset/NOP constants,
// instruction field positions and the held-instruction payload.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0

  // Instruction field positions
  localparam int unsigned OP_LSB     = 0;
  localparam int unsigned OP_W       = 7;
  localparam int unsigned FUNCT3_LSB = 12;
  localparam int unsigned FUNCT3_W   = 3;
  localparam int unsigned FUNCT7_LSB = 25;
  localparam int unsigned FUNCT7_W   = 7;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } fetch_state_e;

  // Instruction held for decode together with its address
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fetch_pkt_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/pc_next.sv
// Next fetch address: sequential pc+4 or word-aligned redirect target,
// flagging a redirect whose low address bits were dropped.
module pc_next
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] pc_plus4_c,
  output logic [XLEN-1:0] next_pc_c,
  output logic            misalign_c
);

  // Modulo-2^32 increment; wraps from the top word back to zero
  assign pc_plus4_c = pc + XLEN'(4);

  always_comb begin
    next_pc_c  = pc_plus4_c;
    misalign_c = 1'b0;
    if (redirect_en) begin
      next_pc_c  = word_align(redirect_target);
      misalign_c = |redirect_target[1:0];
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request, wait for the response,
// then hold the instruction for decode until it is consumed.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [XLEN-1:0]     imem_rdata,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [XLEN-1:0]     instr,
  output logic [OP_W-1:0]     op,
  output logic [FUNCT3_W-1:0] funct3,
  output logic [FUNCT7_W-1:0] funct7,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pc_plus4,
  input  logic                redirect_en,
  input  logic [XLEN-1:0]     redirect_target,
  output logic                misalign_err,
  output logic [XLEN-1:0]     instret
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q;
  fetch_pkt_t      held_q;
  logic [XLEN-1:0] instret_q;
  logic            req_q;
  logic            valid_q;
  logic            misalign_q;

  logic            capture;
  logic            handshake;
  logic [XLEN-1:0] plus4_c;
  logic [XLEN-1:0] next_pc_c;
  logic            misalign_c;

  // fetch_pc equals the held pc while in S_VALID, so one adder serves both uses
  pc_next u_pc_next (
    .pc              (fetch_pc_q),
    .redirect_en     (redirect_en),
    .redirect_target (redirect_target),
    .pc_plus4_c      (plus4_c),
    .next_pc_c       (next_pc_c),
    .misalign_c      (misalign_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // A response is only taken in S_WAIT; rvalid alongside a grant is dropped
  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    handshake = 1'b0;
    case (state_q)
      S_REQ: begin
        if (imem_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          capture = 1'b1;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (id_ready) begin
          handshake = 1'b1;
          state_d   = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= word_align(RESET_PC);
      held_q     <= '{instr: NOP_INSTR, pc: RESET_PC, pc_plus4: RESET_PC + XLEN'(4)};
      instret_q  <= '0;
      req_q      <= 1'b1;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      if (handshake) begin
        fetch_pc_q <= next_pc_c;
        instret_q  <= instret_q + XLEN'(1);
      end
      if (capture) begin
        held_q <= '{instr: imem_rdata, pc: fetch_pc_q, pc_plus4: plus4_c};
      end
      req_q      <= (state_d == S_REQ);
      valid_q    <= (state_d == S_VALID);
      misalign_q <= handshake & misalign_c;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = fetch_pc_q;
  assign id_valid     = valid_q;
  assign instr        = held_q.instr;
  assign pc           = held_q.pc;
  assign pc_plus4     = held_q.pc_plus4;
  assign misalign_err = misalign_q;
  assign instret      = instret_q;

  assign op     = held_q.instr[OP_LSB +: OP_W];
  assign funct3 = held_q.instr[FUNCT3_LSB +: FUNCT3_W];
  assign funct7 = held_q.instr[FUNCT7_LSB +: FUNCT7_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory responder with programmable
// grant/response delays and a transaction-level model of the fetch stream.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect_en;
  logic [31:0] redirect_target;
  logic        misalign_err;
  logic [31:0] instret;

  int checks   = 0;
  int failures = 0;

  fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .id_valid        (id_valid),
    .id_ready        (id_ready),
    .instr           (instr),
    .op              (op),
    .funct3          (funct3),
    .funct7          (funct7),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .redirect_en     (redirect_en),
    .redirect_target (redirect_target),
    .misalign_err    (misalign_err),
    .instret         (instret)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Instruction memory contents: a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00A0_0033;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  int          gnt_delay = 0;
  int          rv_delay  = 0;
  bit          spur      = 1'b0;
  bit          stale_cfg = 1'b0;
  bit          g;
  logic [31:0] ga;
  bit          pending;
  logic [31:0] paddr;
  int          rvcnt;
  int          reqcnt;

  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    pending     = 1'b0;
    paddr       = '0;
    rvcnt       = 0;
    reqcnt      = 0;
    forever begin
      @(negedge clk);
      g  = rst && imem_req && imem_gnt;
      ga = imem_addr;
      @(posedge clk);
      #1;
      if (!rst) begin
        pending     = 1'b0;
        reqcnt      = 0;
        imem_rvalid = stale_cfg;
        imem_rdata  = 32'hBAD0_0BAD;
        imem_gnt    = (gnt_delay == 0);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hBAD0_0000 | 32'(rvcnt);
        if (g) begin
          pending = 1'b1;
          paddr   = ga;
          rvcnt   = 0;
        end
        if (pending) begin
          if (rvcnt == rv_delay) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(paddr);
            pending     = 1'b0;
          end else begin
            rvcnt++;
          end
        end
        if (gnt_delay == 0) begin
          imem_gnt = 1'b1;
        end else if (imem_req) begin
          if (reqcnt == gnt_delay) begin
            imem_gnt = 1'b1;
            reqcnt   = 0;
          end else begin
            imem_gnt = 1'b0;
            reqcnt++;
          end
        end else begin
          imem_gnt = 1'b0;
          reqcnt   = 0;
        end
        if (spur && imem_gnt && imem_req && !imem_rvalid) begin
          imem_rvalid = 1'b1;
          imem_rdata  = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // ---------------- transaction model + compare ----------------
  logic [31:0] exp_fetch;
  logic [31:0] last_grant;
  logic [31:0] exp_instret;
  logic [31:0] exp_i;
  logic        mis_pend;
  int          preload_cnt  = 0;
  int          preload_seen = 0;

  initial begin
    exp_fetch   = RESET_PC;
    last_grant  = RESET_PC;
    exp_instret = '0;
    exp_i       = '0;
    mis_pend    = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_fetch   = RESET_PC;
        last_grant  = RESET_PC;
        exp_instret = '0;
        mis_pend    = 1'b0;
      end else begin
        if (preload_cnt != preload_seen) begin
          preload_seen = preload_cnt;
          exp_instret  = 32'hFFFF_FFFF;
        end
        check("m_instret", instret, exp_instret);
        check("m_misalign", 32'(misalign_err), 32'(mis_pend));
        mis_pend = 1'b0;
        check("m_req_valid_excl", 32'(imem_req & id_valid), 32'd0);
        if (imem_req) begin
          check("m_imem_addr", imem_addr, exp_fetch);
          if (imem_gnt) last_grant = exp_fetch;
        end
        if (id_valid) begin
          exp_i = mem_word(last_grant);
          check("m_instr", instr, exp_i);
          check("m_pc", pc, last_grant);
          check("m_pc_plus4", pc_plus4, last_grant + 32'd4);
          check("m_op", 32'(op), 32'(exp_i[6:0]));
          check("m_funct3", 32'(funct3), 32'(exp_i[14:12]));
          check("m_funct7", 32'(funct7), 32'(exp_i[31:25]));
          if (id_ready) begin
            exp_instret = exp_instret + 32'd1;
            mis_pend    = redirect_en && (redirect_target[1:0] != 2'b00);
            exp_fetch   = redirect_en ? (redirect_target & ~32'd3) : last_grant + 32'd4;
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic handshake(input logic en, input logic [31:0] tgt);
    @(posedge clk); #2;
    id_ready        = 1'b1;
    redirect_en     = en;
    redirect_target = tgt;
    @(posedge clk); #2;
    id_ready    = 1'b0;
    redirect_en = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int n);
    bit done;
    done = 1'b0;
    n    = 0;
    while (!done) begin
      @(negedge clk);
      if (id_valid) begin
        done = 1'b1;
      end else begin
        n++;
        if (n > 100) begin
          check({name, "_timeout"}, 32'(id_valid), 32'd1);
          done = 1'b1;
        end
      end
    end
  endtask

  logic [8:0] vpat;
  int         n;

  initial begin
    rst             = 1'b0;
    id_ready        = 1'b0;
    redirect_en     = 1'b0;
    redirect_target = '0;
    vpat            = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_pc", pc, 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    check("rst_imem_addr", imem_addr, 32'h0);

    // Back-to-back fetch: grant always, response next cycle, consumer always ready
    @(posedge clk); #3;
    rst      = 1'b1;
    id_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      vpat[k] = id_valid;
      if (k == 0) begin
        check("a_first_req", 32'(imem_req), 32'd1);
        check("a_first_addr", imem_addr, 32'h0);
      end
      if (id_valid) check("a_pc", pc, 32'((k / 3) * 4));
    end
    check("a_valid_pattern", 32'(vpat), 32'h124);
    @(negedge clk);
    check("a_instret3", instret, 32'd3);

    // Stall in S_VALID with redirect pulsing while not consumed
    @(posedge clk); #2;
    id_ready = 1'b0;
    wait_valid("b_wait", n);
    check("b_pc", pc, 32'h0000_000C);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      redirect_en     = (i % 2 == 0);
      redirect_target = 32'h0000_0200;
      @(negedge clk);
      check("b_hold_pc", pc, 32'h0000_000C);
      check("b_hold_req", 32'(imem_req), 32'd0);
      check("b_hold_instret", instret, 32'd3);
    end
    handshake(1'b0, 32'h0);
    @(negedge clk);
    check("b_next_addr", imem_addr, 32'h0000_0010);

    // Redirects at pc 0x10: aligned, then misaligned
    wait_valid("c_wait0", n);
    check("c_pc", pc, 32'h0000_0010);
    handshake(1'b1, 32'h0000_0100);
    @(negedge clk);
    check("c_addr_aligned", imem_addr, 32'h0000_0100);
    check("c_no_misalign", 32'(misalign_err), 32'd0);
    wait_valid("c_wait1", n);
    handshake(1'b1, 32'h0000_0102);
    @(negedge clk);
    check("c_addr_misaligned", imem_addr, 32'h0000_0100);
    check("c_misalign_pulse", 32'(misalign_err), 32'd1);
    @(negedge clk);
    check("c_misalign_clear", 32'(misalign_err), 32'd0);

    // Slow memory: grant after 4 idle cycles, data 3 cycles after grant
    wait_valid("d_wait0", n);
    gnt_delay = 4;
    rv_delay  = 3;
    spur      = 1'b1;
    handshake(1'b0, 32'h0);
    n = 0;
    begin
      bit done;
      done = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (id_valid || n > 40) begin
          done = 1'b1;
        end else begin
          check("d_instr_held", instr, mem_word(32'h0000_0100));
          n++;
        end
      end
    end
    check("d_latency", 32'(n), 32'd9);
    check("d_pc", pc, 32'h0000_0104);
    gnt_delay = 0;
    rv_delay  = 0;
    spur      = 1'b0;

    // Address wrap and instret wrap
    handshake(1'b1, 32'hFFFF_FFFC);
    @(negedge clk);
    check("e_addr_top", imem_addr, 32'hFFFF_FFFC);
    wait_valid("e_wait", n);
    check("e_pc_top", pc, 32'hFFFF_FFFC);
    check("e_pc_plus4_wrap", pc_plus4, 32'h0);
    @(posedge clk); #2;
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    preload_cnt++;
    @(negedge clk);
    check("e_instret_preload", instret, 32'hFFFF_FFFF);
    handshake(1'b0, 32'h0);
    rv_delay = 5;
    @(negedge clk);
    check("e_addr_wrap", imem_addr, 32'h0);
    check("e_instret_wrap", instret, 32'h0);

    // Reset while a response is outstanding, stale rvalid after release
    @(negedge clk);
    check("f_in_wait_req", 32'(imem_req), 32'd0);
    @(posedge clk); #2;
    rst       = 1'b0;
    stale_cfg = 1'b1;
    rv_delay  = 0;
    @(negedge clk);
    check("f_rst_valid", 32'(id_valid), 32'd0);
    check("f_rst_pc", pc, 32'h0);
    check("f_rst_instr", instr, 32'h0000_0013);
    @(posedge clk); #3;
    rst = 1'b1;
    @(negedge clk);
    check("f_first_req", 32'(imem_req), 32'd1);
    check("f_first_addr", imem_addr, 32'h0);
    @(posedge clk); #2;
    stale_cfg = 1'b0;
    wait_valid("f_wait", n);
    check("f_pc", pc, 32'h0);
    check("f_instr", instr, 32'h00A0_0033);
    check("f_instret", instret, 32'h0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
